// File: rtl/ptr_sync_multi.sv
// Gray-pointer synchroniser with configurable depth, binary decode, advance reporting
// and sticky detection of illegal multi-bit gray jumps.
module ptr_sync_multi #(
    parameter int ADDRBITS = 8,
    parameter int STAGES   = 2
) (
    input  logic                i_clk_out,
    input  logic                i_rst,
    input  logic                i_sync_flush,
    input  logic                i_err_clr,
    input  logic [ADDRBITS:0]   i_ptr_gray,
    output logic [ADDRBITS:0]   o_sync_ptr_gray,
    output logic [ADDRBITS:0]   o_sync_ptr_bin,
    output logic                o_ptr_adv,
    output logic [ADDRBITS:0]   o_adv_delta,
    output logic                o_gray_err
);

    localparam int PW = ADDRBITS + 1;

    if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
        $error("ptr_sync_multi: STAGES must be in 2..4");
    end

    logic [PW-1:0] r_sync [STAGES];
    logic [PW-1:0] r_prev_gray;
    logic [PW-1:0] r_bin;
    logic [PW-1:0] r_delta;
    logic          r_adv;
    logic          r_err;

    logic [PW-1:0] w_gray;
    logic [PW-1:0] w_bin;
    logic [PW-1:0] w_diff;
    logic          w_multi;

    assign w_gray = r_sync[STAGES-1];
    assign w_diff = w_gray ^ r_prev_gray;
    assign w_multi = ($countones(w_diff) > 1);

    // Binary bit i is the XOR of all gray bits at or above i.
    always_comb begin
        w_bin = '0;
        for (int i = 0; i < PW; i++) begin
            w_bin[i] = ^(w_gray >> i);
        end
    end

    always_ff @(posedge i_clk_out or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < STAGES; i++) begin
                r_sync[i] <= '0;
            end
            r_prev_gray <= '0;
            r_bin       <= '0;
            r_delta     <= '0;
            r_adv       <= 1'b0;
            r_err       <= 1'b0;
        end else if (i_sync_flush) begin
            for (int i = 0; i < STAGES; i++) begin
                r_sync[i] <= '0;
            end
            r_prev_gray <= '0;
            r_bin       <= '0;
            r_delta     <= '0;
            r_adv       <= 1'b0;
            if (i_err_clr) begin
                r_err <= 1'b0;
            end
        end else begin
            r_sync[0] <= i_ptr_gray;
            for (int i = 1; i < STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_prev_gray <= w_gray;
            r_bin       <= w_bin;
            r_delta     <= w_bin - r_bin;
            r_adv       <= (w_bin != r_bin);
            // A fresh detection outranks a clear on the same edge.
            r_err       <= w_multi | (r_err & ~i_err_clr);
        end
    end

    assign o_sync_ptr_gray = w_gray;
    assign o_sync_ptr_bin  = r_bin;
    assign o_ptr_adv       = r_adv;
    assign o_adv_delta     = r_delta;
    assign o_gray_err      = r_err;

endmodule

// File: tb/tb_ptr_sync_multi.sv
// Bench for ptr_sync_multi at STAGES=2,3,4 side by side, checked against a
// sample-history reference model.
module tb_ptr_sync_multi;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic       clr;
    logic [8:0] gin;

    logic [8:0] o_sg    [3];
    logic [8:0] o_bin   [3];
    logic       o_adv   [3];
    logic [8:0] o_delta [3];
    logic       o_err   [3];

    int n_assert = 0;
    int n_fail   = 0;

    // Every input sample accepted since the last reset or flush, oldest first.
    logic [8:0] hist[$];
    logic       m_err [3];
    int         first_e [3];

    always #5 clk = ~clk;

    ptr_sync_multi #(.ADDRBITS(8), .STAGES(2)) dut2 (
        .i_clk_out(clk), .i_rst(rst), .i_sync_flush(flush), .i_err_clr(clr), .i_ptr_gray(gin),
        .o_sync_ptr_gray(o_sg[0]), .o_sync_ptr_bin(o_bin[0]), .o_ptr_adv(o_adv[0]),
        .o_adv_delta(o_delta[0]), .o_gray_err(o_err[0]));
    ptr_sync_multi #(.ADDRBITS(8), .STAGES(3)) dut3 (
        .i_clk_out(clk), .i_rst(rst), .i_sync_flush(flush), .i_err_clr(clr), .i_ptr_gray(gin),
        .o_sync_ptr_gray(o_sg[1]), .o_sync_ptr_bin(o_bin[1]), .o_ptr_adv(o_adv[1]),
        .o_adv_delta(o_delta[1]), .o_gray_err(o_err[1]));
    ptr_sync_multi #(.ADDRBITS(8), .STAGES(4)) dut4 (
        .i_clk_out(clk), .i_rst(rst), .i_sync_flush(flush), .i_err_clr(clr), .i_ptr_gray(gin),
        .o_sync_ptr_gray(o_sg[2]), .o_sync_ptr_bin(o_bin[2]), .o_ptr_adv(o_adv[2]),
        .o_adv_delta(o_delta[2]), .o_gray_err(o_err[2]));

    function automatic logic [8:0] g2b(input logic [8:0] g);
        logic [8:0] b;
        b[8] = g[8];
        for (int i = 7; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    function automatic logic [8:0] b2g(input logic [8:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic int popc(input logic [8:0] v);
        int c = 0;
        for (int i = 0; i < 9; i++) c += int'(v[i]);
        return c;
    endfunction

    // Sample n-back from the newest in history (1 = newest); zero before history began.
    function automatic logic [8:0] back(input int n);
        int sz = hist.size();
        if (sz >= n) return hist[sz-n];
        return 9'h000;
    endfunction

    task automatic chk(input string tag, input int k, input logic [8:0] got, input logic [8:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s dut%0d got %h expected %h", tag, k + 2, got, exp);
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 3; k++) begin
            int s = k + 2;
            logic [8:0] g_new, g_old, b_new, b_old;
            g_new = back(s + 1);
            g_old = back(s + 2);
            b_new = g2b(g_new);
            b_old = g2b(g_old);
            chk("sync_gray", k, o_sg[k], back(s));
            chk("sync_bin", k, o_bin[k], b_new);
            chk("ptr_adv", k, {8'h0, o_adv[k]}, {8'h0, b_new != b_old});
            chk("adv_delta", k, o_delta[k], b_new - b_old);
            chk("gray_err", k, {8'h0, o_err[k]}, {8'h0, m_err[k]});
        end
    endtask

    // Advance one edge: update the model from the pre-edge inputs, then compare.
    task automatic tick();
        @(posedge clk);
        if (!rst) begin
            if (flush) begin
                hist.delete();
                for (int k = 0; k < 3; k++) m_err[k] = m_err[k] & ~clr;
            end else begin
                hist.push_back(gin);
                for (int k = 0; k < 3; k++) begin
                    bit det = popc(back(k + 3) ^ back(k + 4)) > 1;
                    m_err[k] = det | (m_err[k] & ~clr);
                end
            end
        end
        #1;
        check_all();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic model_reset();
        hist.delete();
        for (int k = 0; k < 3; k++) m_err[k] = 1'b0;
    endtask

    initial begin
        logic [8:0] b;
        rst = 1'b1; flush = 1'b0; clr = 1'b0; gin = 9'h0AB;
        model_reset();

        // T1: held in reset, then hold 0x0AB across release
        ticks(3);
        rst = 1'b0;
        ticks(2);
        chk("t1_gray", 0, o_sg[0], 9'h0AB);
        tick();
        chk("t1_bin", 0, o_bin[0], 9'h0CD);
        ticks(4);

        // T2: single step 0->1 after a clean flush, pulse lands on edge STAGES+1
        flush = 1'b1; clr = 1'b1; gin = 9'h000;
        tick();
        flush = 1'b0; clr = 1'b0;
        ticks(6);
        gin = 9'h001;
        for (int k = 0; k < 3; k++) first_e[k] = 0;
        for (int e = 1; e <= 7; e++) begin
            tick();
            for (int k = 0; k < 3; k++)
                if (o_adv[k] && first_e[k] == 0) first_e[k] = e;
        end
        for (int k = 0; k < 3; k++) chk("t2_adv_edge", k, 9'(first_e[k]), 9'(k + 3));

        // T3: wrap through 0x1FE, 0x1FF, 0x000
        b = 9'h1FD;
        gin = b2g(b);
        ticks(6);
        for (int i = 0; i < 3; i++) begin
            b = b + 9'd1;
            gin = b2g(b);
            ticks(6);
        end
        chk("t3_bin", 0, o_bin[0], 9'h000);

        // T4: illegal jump, clear, clear racing a new jump
        flush = 1'b1; clr = 1'b1; gin = 9'h000;
        tick();
        flush = 1'b0; clr = 1'b0;
        ticks(6);
        gin = 9'h003;
        ticks(7);
        chk("t4_err_set", 0, {8'h0, o_err[0]}, 9'h001);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("t4_err_clr", 0, {8'h0, o_err[0]}, 9'h000);
        ticks(2);
        gin = 9'h00C;
        ticks(2);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("t4_set_wins", 0, {8'h0, o_err[0]}, 9'h001);
        ticks(6);

        // T5: flush at 0x055, gray_err untouched, re-decode from zero
        gin = 9'h055;
        ticks(6);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t5_bin_zero", 0, o_bin[0], 9'h000);
        ticks(3);
        chk("t5_delta", 0, o_delta[0], g2b(9'h055));
        ticks(4);

        // T6: asynchronous reset between edges
        gin = 9'h0F0;
        ticks(3);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all();
        ticks(2);
        rst = 1'b0;
        ticks(7);

        // Random walk with occasional jumps, flushes and clears
        b = g2b(gin);
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 19) == 0) b = 9'($urandom);
            else b = b + 9'($urandom_range(0, 2));
            gin = b2g(b);
            flush = ($urandom_range(0, 49) == 0);
            clr = ($urandom_range(0, 14) == 0);
            tick();
        end
        flush = 1'b0; clr = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
